dvp_byte_capture: RTL and testbench
===================================

// Module: dvp_byte_capture
// PURPOSE
//  Converts the raw 8-bit OV5640 DVP bus into the 16-bit RGB565 pixel stream consumed by the
//  motion-detection top (dvp_vsync/dvp_href/dvp_valid/dvp_data). Pairs bytes, gates whole frames,
//  discards the first SKIP_FRAMES frames after reset, and reports line/frame geometry errors.
//  Sits directly upstream of the motion-detection top, in the camera pixel-clock domain.
// PARAMETERS
//  IMG_HDISP    640  expected pixels per line (2*IMG_HDISP bytes)
//  IMG_VDISP    480  expected lines per frame
//  SKIP_FRAMES  10   frames discarded after reset while sensor settles; 0 = none
//  VSYNC_POL    1    1: cam_vsync high marks blanking; 0: low marks blanking
// PORTS
//  clk          in   1   camera pixel clock; the only clock
//  rst          in   1   synchronous, active-high reset
//  cam_vsync    in   1   raw sensor frame sync
//  cam_href     in   1   raw sensor line valid
//  cam_data     in   8   raw sensor byte, high byte of each pixel first
//  cap_en       in   1   capture enable, sampled only at frame start
//  dvp_vsync    out  1   frame sync, active-high during blanking, aligned to the pixel stream
//  dvp_href     out  1   line valid, aligned to the pixel stream
//  dvp_valid    out  1   one-cycle strobe per assembled pixel
//  dvp_data     out  16  RGB565 pixel {first byte, second byte}
//  frame_cnt    out  8   count of frames passed downstream, wraps 255->0
//  err_line     out  1   sticky per frame: line length != 2*IMG_HDISP bytes, or odd byte count
//  err_frame    out  1   sticky per frame: line count != IMG_VDISP
// BEHAVIOUR
//  - Reset: every output is 0. State goes to SKIP, all counters clear, byte phase clears.
//  - Stage 1 registers cam_* and normalises vsync polarity.
//    vs_rise / vs_fall are detected on stage-1 versus stage-2.
//  - FSM:
//    - SKIP: count vs_fall events. When the count reaches SKIP_FRAMES, go to WAIT. SKIP_FRAMES=0 goes straight to WAIT.
//    - WAIT: on vs_fall, go to ACTIVE if cap_en=1; otherwise stay in WAIT.
//    - ACTIVE: on vs_rise, latch the error flags and return to WAIT. err_* stay valid until the next vs_fall.
//  - Outputs are zero except in ACTIVE. dvp_vsync is the exception: it always follows the normalised vsync,
//    delayed two cycles. This lets downstream see every frame boundary.
//  - Byte pairing:
//    - The phase bit toggles on each href=1 byte and clears when href=0.
//    - Phase 0 captures the high byte. Phase 1 sets dvp_valid=1 and dvp_data={hi,lo}.
//    - Latency: dvp_valid is asserted exactly 2 clk after the second byte appears on cam_data.
//    - dvp_href is cam_href delayed 2 clk, and is gated by ACTIVE.
//  - Line counting:
//    - The byte counter is 12 bits, clears on href fall, and saturates at 4095.
//    - On href fall, set err_line if count != 2*IMG_HDISP or if the count is odd.
//      A trailing odd byte is dropped: no dvp_valid is generated for it.
//    - The line counter is 10 bits, increments on href fall, and clears on vs_fall.
//    - On vs_rise, set err_frame if lines != IMG_VDISP.
//  - frame_cnt increments on vs_rise while leaving ACTIVE.
//  - Simultaneous events:
//    - cap_en changing mid-frame has no effect until the next vs_fall.
//    - vs_rise with href still high closes the line first: the length check runs, then the frame ends.
//    - vsync toggling with no href produces a frame with 0 lines, so err_frame=1.
//  - Reset mid-frame: drops the frame. After reset, a frame is only emitted once
//    SKIP_FRAMES+1 vs_fall events have occurred.
//  - No partial frame is ever emitted: entry to ACTIVE happens only on vs_fall.
// STRUCTURE
//  - Package img_pkg holds:
//    - enum cap_state_t {SKIP, WAIT, ACTIVE}
//    - typedef rgb565_t (16 bit)
//    - localparams BYTES_PER_LINE=2*IMG_HDISP and CNT_W=12
//  - One sub-module, dvp_sync_edge, provides the polarity normalisation, the 2-deep delay line, and the rise/fall
//    detection. It is instantiated for both vsync and href.
//  - The FSM, counters and byte pairing stay in the top module.
// TESTING
//  1. SKIP_FRAMES=2, three 4x2 frames of bytes 0x12,0x34,...
//     -> no dvp_valid in frames 1-2.
//     -> frame 3 yields 8 strobes; the first has dvp_data=16'h1234, 2 clk after the 0x34 byte.
//     -> frame_cnt=1.
//  2. A 640x480 frame with cap_en=1 -> 307200 dvp_valid strobes, err_line=0, err_frame=0.
//  3. One line of 1279 bytes -> 639 strobes on that line, err_line=1; err_line clears on the next vs_fall.
//  4. cap_en drops mid-frame -> that frame completes in full; the next frame has no dvp_valid.
//     dvp_vsync keeps toggling throughout.
//  5. rst pulsed for 1 clk at line 100 -> all outputs 0 on the next clk.
//     No pixels until SKIP_FRAMES+1 vs_fall events have occurred.
//  6. VSYNC_POL=0 with 479 lines -> frames are gated correctly and err_frame=1.

Source files
------------

// File: rtl/img_pkg.sv
// Shared types and geometry constants for the DVP capture path.
package img_pkg;

  typedef enum logic [1:0] {
    SKIP   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2
  } cap_state_t;

  typedef logic [15:0] rgb565_t;

  localparam int IMG_HDISP_DFLT = 640;
  localparam int BYTES_PER_LINE = 2 * IMG_HDISP_DFLT;
  localparam int CNT_W          = 12;

endpackage

// File: rtl/dvp_sync_edge.sv
// Polarity-normalised two-stage delay line with rise/fall detection
// between the first and second stage.
module dvp_sync_edge #(
  parameter bit POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_s1,
  output logic o_s2,
  output logic o_rise,
  output logic o_fall
);

  logic w_norm;
  logic r_s1;
  logic r_s2;

  assign w_norm = POL ? i_sig : ~i_sig;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= w_norm;
      r_s2 <= r_s1;
    end
  end

  assign o_s1   = r_s1;
  assign o_s2   = r_s2;
  assign o_rise = r_s1 & ~r_s2;
  assign o_fall = ~r_s1 & r_s2;

endmodule

// File: rtl/dvp_byte_capture.sv
// Pairs OV5640 DVP bytes into RGB565 pixels, gates whole frames and flags
// line/frame geometry errors. Runs entirely on the camera pixel clock.
//
// state  | meaning
// SKIP   | discarding frames while the sensor settles
// WAIT   | between frames; cap_en sampled at the next frame start
// ACTIVE | current frame is passed downstream
module dvp_byte_capture
  import img_pkg::*;
#(
  parameter int IMG_HDISP   = BYTES_PER_LINE / 2,
  parameter int IMG_VDISP   = 480,
  parameter int SKIP_FRAMES = 10,
  parameter bit VSYNC_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        cap_en,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic        dvp_valid,
  output logic [15:0] dvp_data,
  output logic [7:0]  frame_cnt,
  output logic        err_line,
  output logic        err_frame
);

  localparam logic [CNT_W-1:0] LINE_BYTES = CNT_W'(2 * IMG_HDISP);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;
  localparam logic [9:0]       LINES      = 10'(IMG_VDISP);
  localparam logic [7:0]       SKIP_LAST  = (SKIP_FRAMES > 0) ? 8'(SKIP_FRAMES - 1) : 8'd0;

  cap_state_t       r_state;
  cap_state_t       w_state_nxt;
  logic             w_vs_s1, w_vs_s2, w_vs_rise, w_vs_fall;
  logic             w_hr_s1, w_hr_s2, w_hr_rise, w_hr_fall;
  logic [7:0]       r_data_s1;
  logic [7:0]       r_hi;
  logic [7:0]       r_skip_cnt;
  logic [7:0]       r_frame_cnt;
  logic             r_phase;
  logic             r_line_acc;
  logic             r_valid;
  logic             r_href_o;
  logic             r_err_line;
  logic             r_err_frame;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [9:0]       r_line_cnt;
  logic [9:0]       w_lines_total;
  rgb565_t          r_pix;
  logic             w_active;
  logic             w_line_end;
  logic             w_line_bad;
  logic             w_unused;

  dvp_sync_edge #(.POL(VSYNC_POL)) u_vs (
    .clk(clk), .rst(rst), .i_sig(cam_vsync),
    .o_s1(w_vs_s1), .o_s2(w_vs_s2), .o_rise(w_vs_rise), .o_fall(w_vs_fall)
  );

  dvp_sync_edge #(.POL(1'b1)) u_hr (
    .clk(clk), .rst(rst), .i_sig(cam_href),
    .o_s1(w_hr_s1), .o_s2(w_hr_s2), .o_rise(w_hr_rise), .o_fall(w_hr_fall)
  );

  assign w_active      = (r_state == ACTIVE);
  // A frame ending while href is still high closes that line in the same cycle.
  assign w_line_end    = w_hr_fall | (w_vs_rise & w_hr_s1 & w_hr_s2);
  assign w_line_bad    = (r_byte_cnt != LINE_BYTES) | r_byte_cnt[0];
  assign w_lines_total = r_line_cnt + {9'd0, w_line_end};
  assign w_unused      = w_vs_s1 ^ w_hr_rise;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SKIP: begin
        if (SKIP_FRAMES == 0)
          w_state_nxt = WAIT;
        else if (w_vs_fall && r_skip_cnt == SKIP_LAST)
          w_state_nxt = WAIT;
      end
      WAIT:    if (w_vs_fall && cap_en) w_state_nxt = ACTIVE;
      ACTIVE:  if (w_vs_rise) w_state_nxt = WAIT;
      default: w_state_nxt = SKIP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= SKIP;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_s1   <= '0;
      r_hi        <= '0;
      r_skip_cnt  <= '0;
      r_frame_cnt <= '0;
      r_phase     <= 1'b0;
      r_line_acc  <= 1'b0;
      r_valid     <= 1'b0;
      r_href_o    <= 1'b0;
      r_err_line  <= 1'b0;
      r_err_frame <= 1'b0;
      r_byte_cnt  <= '0;
      r_line_cnt  <= '0;
      r_pix       <= '0;
    end else begin
      r_data_s1 <= cam_data;

      if (r_state == SKIP && w_vs_fall) r_skip_cnt <= r_skip_cnt + 8'd1;

      r_phase <= w_hr_s1 ? ~r_phase : 1'b0;
      if (w_hr_s1 && !r_phase) r_hi <= r_data_s1;

      r_href_o <= w_active & w_hr_s1;
      r_valid  <= w_active & w_hr_s1 & r_phase;
      if (!w_active)               r_pix <= '0;
      else if (w_hr_s1 && r_phase) r_pix <= {r_hi, r_data_s1};

      if (w_line_end)                               r_byte_cnt <= '0;
      else if (w_hr_s1 && r_byte_cnt != CNT_SAT)    r_byte_cnt <= r_byte_cnt + 1'b1;

      if (w_vs_fall)       r_line_cnt <= '0;
      else if (w_line_end) r_line_cnt <= r_line_cnt + 10'd1;

      if (w_vs_fall)                      r_line_acc <= 1'b0;
      else if (w_line_end && w_line_bad)  r_line_acc <= 1'b1;

      if (w_vs_fall) begin
        r_err_line  <= 1'b0;
        r_err_frame <= 1'b0;
      end else if (w_active && w_vs_rise) begin
        r_err_line  <= r_line_acc | (w_line_end & w_line_bad);
        r_err_frame <= (w_lines_total != LINES);
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign dvp_vsync = w_vs_s2;
  assign dvp_href  = r_href_o;
  assign dvp_valid = r_valid;
  assign dvp_data  = r_pix;
  assign frame_cnt = r_frame_cnt;
  assign err_line  = r_err_line;
  assign err_frame = r_err_frame;

endmodule

// File: tb/tb_dvp_byte_capture.sv
// Frame-level stimulus for two capture instances (positive and inverted vsync),
// with a per-pixel scoreboard that checks data and latency.
module tb_dvp_byte_capture;

  localparam int HD = 4;
  localparam int VD = 2;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    int nlines; int bad_line; int bad_len;
    bit join_end; bit cap_en; bit drop_mid; bit rst_mid;
    bit act_a; int str_a; bit el_a; bit ef_a; int fc_a;
    bit act_b; int str_b; bit el_b; bit ef_b; int fc_b;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cam_vsync = 1'b1;
  logic        cam_vsync_n;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'd0;
  logic        cap_en = 1'b0;

  logic        a_vsync, a_href, a_valid, a_el, a_ef;
  logic [15:0] a_data;
  logic [7:0]  a_fc;
  logic        b_vsync, b_href, b_valid, b_el, b_ef;
  logic [15:0] b_data;
  logic [7:0]  b_fc;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   str_a = 0, str_b = 0, hc_a = 0, hc_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  assign cam_vsync_n = ~cam_vsync;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dvp_byte_capture #(.IMG_HDISP(HD), .IMG_VDISP(VD), .SKIP_FRAMES(2), .VSYNC_POL(1'b1)) u_a (
    .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .cap_en(cap_en), .dvp_vsync(a_vsync), .dvp_href(a_href), .dvp_valid(a_valid),
    .dvp_data(a_data), .frame_cnt(a_fc), .err_line(a_el), .err_frame(a_ef)
  );

  dvp_byte_capture #(.IMG_HDISP(HD), .IMG_VDISP(VD), .SKIP_FRAMES(0), .VSYNC_POL(1'b0)) u_b (
    .clk(clk), .rst(rst), .cam_vsync(cam_vsync_n), .cam_href(cam_href), .cam_data(cam_data),
    .cap_en(cap_en), .dvp_vsync(b_vsync), .dvp_href(b_href), .dvp_valid(b_valid),
    .dvp_data(b_data), .frame_cnt(b_fc), .err_line(b_el), .err_frame(b_ef)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (a_valid) begin
      str_a++;
      if (q_a.size() == 0) check("a_unexpected_pix", a_valid, 1'b0);
      else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_pix", a_data, e.data);
        check("a_pix_cycle", cyc, e.cyc);
      end
    end
    if (a_href) hc_a++;
  end

  always @(negedge clk) begin
    if (b_valid) begin
      str_b++;
      if (q_b.size() == 0) check("b_unexpected_pix", b_valid, 1'b0);
      else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_pix", b_data, e.data);
        check("b_pix_cycle", cyc, e.cyc);
      end
    end
    if (b_href) hc_b++;
  end

  task automatic run_row(input vec_t v);
    bit         act_a, act_b;
    logic [7:0] b, prev;
    int         blen, hx_a, hx_b;
    act_a = v.act_a;
    act_b = v.act_b;
    hx_a = 0;
    hx_b = 0;
    cap_en = v.cap_en;
    str_a = 0; str_b = 0; hc_a = 0; hc_b = 0;
    tick(3);
    cam_vsync = 1'b0;
    tick(4);
    check("a_vsync_in_frame", a_vsync, 1'b0);
    check("b_vsync_in_frame", b_vsync, 1'b0);
    check("a_err_cleared", {a_el, a_ef}, 2'b00);
    check("b_err_cleared", {b_el, b_ef}, 2'b00);
    b = 8'h12;
    prev = 8'h00;
    for (int ln = 0; ln < v.nlines; ln++) begin
      blen = (ln == v.bad_line) ? v.bad_len : 2 * HD;
      cam_href = 1'b1;
      for (int k = 0; k < blen; k++) begin
        cam_data = b;
        if (k % 2 == 1) begin
          if (act_a) q_a.push_back('{{prev, b}, cyc + 2});
          if (act_b) q_b.push_back('{{prev, b}, cyc + 2});
        end
        if (act_a) hx_a++;
        if (act_b) hx_b++;
        prev = b;
        b = b + 8'h22;
        tick(1);
      end
      cam_href = 1'b0;
      cam_data = 8'h00;
      if (v.join_end && ln == v.nlines - 1) cam_vsync = 1'b1;
      if (v.drop_mid && ln == 0) cap_en = 1'b0;
      tick(4);
      if (v.rst_mid && ln == 0) begin
        check("a_queue_before_rst", q_a.size(), 0);
        check("b_queue_before_rst", q_b.size(), 0);
        rst = 1'b1;
        tick(1);
        check("a_outputs_after_rst", {a_valid, a_href, a_vsync, a_el, a_ef, a_fc, a_data}, 0);
        check("b_outputs_after_rst", {b_valid, b_href, b_vsync, b_el, b_ef, b_fc, b_data}, 0);
        rst = 1'b0;
        act_a = 1'b0;
        act_b = 1'b0;
      end
    end
    cam_vsync = 1'b1;
    tick(6);
    check("a_strobes", str_a, v.str_a);
    check("b_strobes", str_b, v.str_b);
    check("a_href_cycles", hc_a, hx_a);
    check("b_href_cycles", hc_b, hx_b);
    check("a_queue_empty", q_a.size(), 0);
    check("b_queue_empty", q_b.size(), 0);
    check("a_err_line", a_el, v.el_a);
    check("a_err_frame", a_ef, v.ef_a);
    check("a_frame_cnt", a_fc, v.fc_a);
    check("b_err_line", b_el, v.el_b);
    check("b_err_frame", b_ef, v.ef_b);
    check("b_frame_cnt", b_fc, v.fc_b);
    check("a_vsync_blank", a_vsync, 1'b1);
    check("b_vsync_blank", b_vsync, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: run exceeded time limit at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[17];
    //          nl bl blen je ce dm rm | aA sA  eLA eFA fcA | aB sB  eLB eFB fcB
    tbl[0]  = '{2, -1, 0, 0, 1, 0, 0,  0, 0,  0, 0, 0,   1, 8,  0, 0, 1};
    tbl[1]  = '{2, -1, 0, 0, 1, 0, 0,  0, 0,  0, 0, 0,   1, 8,  0, 0, 2};
    tbl[2]  = '{2, -1, 0, 0, 1, 0, 0,  1, 8,  0, 0, 1,   1, 8,  0, 0, 3};
    tbl[3]  = '{2,  0, 7, 0, 1, 0, 0,  1, 7,  1, 0, 2,   1, 7,  1, 0, 4};
    tbl[4]  = '{2, -1, 0, 0, 1, 0, 0,  1, 8,  0, 0, 3,   1, 8,  0, 0, 5};
    tbl[5]  = '{1, -1, 0, 0, 1, 0, 0,  1, 4,  0, 1, 4,   1, 4,  0, 1, 6};
    tbl[6]  = '{0, -1, 0, 0, 1, 0, 0,  1, 0,  0, 1, 5,   1, 0,  0, 1, 7};
    tbl[7]  = '{3, -1, 0, 0, 1, 0, 0,  1, 12, 0, 1, 6,   1, 12, 0, 1, 8};
    tbl[8]  = '{2,  1, 6, 1, 1, 0, 0,  1, 7,  1, 0, 7,   1, 7,  1, 0, 9};
    tbl[9]  = '{2, -1, 0, 1, 1, 0, 0,  1, 8,  0, 0, 8,   1, 8,  0, 0, 10};
    tbl[10] = '{2, -1, 0, 0, 1, 1, 0,  1, 8,  0, 0, 9,   1, 8,  0, 0, 11};
    tbl[11] = '{2, -1, 0, 0, 0, 0, 0,  0, 0,  0, 0, 9,   0, 0,  0, 0, 11};
    tbl[12] = '{2, -1, 0, 0, 1, 0, 0,  1, 8,  0, 0, 10,  1, 8,  0, 0, 12};
    tbl[13] = '{2, -1, 0, 0, 1, 0, 1,  1, 4,  0, 0, 0,   1, 4,  0, 0, 0};
    tbl[14] = '{2, -1, 0, 0, 1, 0, 0,  0, 0,  0, 0, 0,   1, 8,  0, 0, 1};
    tbl[15] = '{2, -1, 0, 0, 1, 0, 0,  0, 0,  0, 0, 0,   1, 8,  0, 0, 2};
    tbl[16] = '{2, -1, 0, 0, 1, 0, 0,  1, 8,  0, 0, 1,   1, 8,  0, 0, 3};

    tick(3);
    check("a_reset_outputs", {a_valid, a_href, a_vsync, a_el, a_ef, a_fc, a_data}, 0);
    check("b_reset_outputs", {b_valid, b_href, b_vsync, b_el, b_ef, b_fc, b_data}, 0);
    rst = 1'b0;
    tick(4);
    check("a_vsync_follows", a_vsync, 1'b1);
    check("b_vsync_follows", b_vsync, 1'b1);

    for (int i = 0; i < 17; i++) run_row(tbl[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
